// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control FSM: opcodes, functs, state and mux/ALU codes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [1:0] PCSRC_PC4 = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_REG = 2'd2;
  localparam logic [1:0] PCSRC_JMP = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;

  typedef struct packed {
    logic is_r;
    logic is_jr;
    logic is_mem;
    logic is_ld;
    logic is_br;
    logic is_j;
    logic is_jal;
    logic is_imm;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction-class decode from opcode/funct for the control FSM.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU, FN_SUBU, FN_SLT: dec_o.is_r    = 1'b1;
          FN_JR:                    dec_o.is_jr   = 1'b1;
          default:                  dec_o.illegal = 1'b1;
        endcase
      end
      OP_ORI, OP_LUI: dec_o.is_imm = 1'b1;
      OP_LW: begin
        dec_o.is_mem = 1'b1;
        dec_o.is_ld  = 1'b1;
      end
      OP_SW:   dec_o.is_mem  = 1'b1;
      OP_BEQ:  dec_o.is_br   = 1'b1;
      OP_J:    dec_o.is_j    = 1'b1;
      OP_JAL:  dec_o.is_jal  = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main IF/ID/EXE/MEM/WB control FSM of the multi-cycle MIPS core with a retired-instruction counter.
// Optional MCCTRL_MEM_WAIT_EN adds mem_ready so IF and MEM stall until memory responds.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
`ifdef MCCTRL_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               PCWr,
  output logic [1:0]         PCSrc,
  output logic               IRWr,
  output logic               RegWr,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               MemRd,
  output logic               MemWr,
  output logic               ALUSrcB,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  dec_t             dec;
  logic             memOk;
  logic             retire;
  logic [2:0]       aluOp;

  mc_ctrl_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .dec_o    (dec)
  );

`ifdef MCCTRL_MEM_WAIT_EN
  assign memOk = mem_ready;
`else
  assign memOk = 1'b1;
`endif

  // ALU controls are driven from EXE onwards and held through MEM and WB
  always_comb begin
    aluOp   = ALU_ADD;
    ALUSrcB = 1'b0;
    ExtOp   = 1'b0;
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      ExtOp   = dec.is_mem | dec.is_br;
      ALUSrcB = dec.is_mem | dec.is_imm;
      if (dec.is_br)
        aluOp = ALU_SUB;
      else if (dec.is_imm)
        aluOp = (opcode == OP_LUI) ? ALU_LUI : ALU_OR;
      else if (dec.is_r && funct == FN_SUBU)
        aluOp = ALU_SUB;
      else if (dec.is_r && funct == FN_SLT)
        aluOp = ALU_SLT;
    end
  end

  assign ALUOp = ALUOP_W'(aluOp);

  always_comb begin
    state_d  = state_q;
    PCWr     = 1'b0;
    PCSrc    = PCSRC_PC4;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    RegDst   = DST_RT;
    MemtoReg = WB_ALU;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_IF: begin
        PCWr = memOk;
        IRWr = memOk;
        if (memOk) state_d = S_ID;
      end
      S_ID: begin
        state_d = S_IF;
        if (dec.illegal) begin
          illegal = 1'b1;
        end else if (dec.is_j || dec.is_jal) begin
          PCWr  = 1'b1;
          PCSrc = PCSRC_JMP;
          if (dec.is_jal) begin
            RegWr    = 1'b1;
            RegDst   = DST_R31;
            MemtoReg = WB_PC;
          end
        end else if (dec.is_jr) begin
          PCWr  = 1'b1;
          PCSrc = PCSRC_REG;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (dec.is_br) begin
          PCSrc   = PCSRC_BR;
          PCWr    = zero;
          state_d = S_IF;
        end else if (dec.is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dec.is_ld) begin
          MemRd = 1'b1;
          if (memOk) state_d = S_WB;
        end else begin
          MemWr = memOk;
          if (memOk) state_d = S_IF;
        end
      end
      S_WB: begin
        RegWr    = 1'b1;
        RegDst   = dec.is_r ? DST_RD : DST_RT;
        MemtoReg = dec.is_ld ? WB_MEM : WB_ALU;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase
    // State is already forced to IF asynchronously, so the strobes must be masked too
    if (reset) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RegWr   = 1'b0;
      MemRd   = 1'b0;
      MemWr   = 1'b0;
      illegal = 1'b0;
    end
  end

  assign retire = (state_d == S_IF) && (state_q != S_IF) &&
                  !(state_q == S_ID && dec.illegal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
